valid_data_fifo: RTL

//   Upstream buffering stage for the registered data path. Accepts WIDTH-bit beats on a

---
 rtl/valid_data_fifo_pkg.sv | 17 +
 rtl/valid_data_fifo_checker.sv | 33 +++
 rtl/valid_data_fifo.sv | 86 ++++++++
 3 files changed

// File: rtl/valid_data_fifo_pkg.sv
// Shared sizing helpers and beat type for the valid/data FIFO.
package valid_data_fifo_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 4;

  typedef logic [DEF_WIDTH-1:0] beat_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/valid_data_fifo_checker.sv
// Handshake and occupancy assertions for valid_data_fifo.
module valid_data_fifo_checker
  import valid_data_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic                      CLK,
  input logic                      RESET,
  input logic                      I_valid,
  input logic                      I_ready,
  input logic [WIDTH-1:0]          O_data,
  input logic                      O_valid,
  input logic                      O_ready,
  input logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  a_cnt_max: assert property (@(posedge CLK) disable iff (RESET)
    count <= FULL);

  a_no_push_full: assert property (@(posedge CLK) disable iff (RESET)
    !(count == FULL && I_valid && I_ready));

  a_no_pop_empty: assert property (@(posedge CLK) disable iff (RESET)
    !(count == '0 && O_valid && O_ready));

  a_stall_stable: assert property (@(posedge CLK) disable iff (RESET)
    (O_valid && !O_ready) |=> $stable(O_data));

endmodule

// File: rtl/valid_data_fifo.sv
// First-word-fall-through FIFO; define VALID_DATA_FIFO_ASSERT_EN
// to bind in valid_data_fifo_checker.
module valid_data_fifo
  import valid_data_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [WIDTH-1:0]        I_data,
  input  logic                    I_valid,
  output logic                    I_ready,
  output logic [WIDTH-1:0]        O_data,
  output logic                    O_valid,
  input  logic                    O_ready,
  output logic [cnt_w(DEPTH)-1:0] count
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;

  // ready depends only on state and reset, never on O_ready
  assign I_ready = ~RESET & (cnt_q != FULL);
  assign O_valid = (cnt_q != '0);
  assign O_data  = O_valid ? mem[rd_ptr_q] : '0;
  assign count   = cnt_q;

  assign push = I_valid & I_ready;
  assign pop  = O_valid & O_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_q] <= I_data;
  end

`ifdef VALID_DATA_FIFO_ASSERT_EN
  valid_data_fifo_checker #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_chk (
    .CLK     (CLK),
    .RESET   (RESET),
    .I_valid (I_valid),
    .I_ready (I_ready),
    .O_data  (O_data),
    .O_valid (O_valid),
    .O_ready (O_ready),
    .count   (count)
  );
`else
  // checker not built
`endif

endmodule
